lsu_dmem_ctrl: RTL

- Load/store unit between the PROCESSOR datapath and the data memory.
- Converts a core load/store (RISC-V funct3 encoding) into a word-addressed memory request with byte enables, lane-replicated write data and a valid/ready handshake.
- On loads, extracts and sign- or zero-extends the result.
- Stalls the core until the access completes, and flags misaligned accesses and memory timeouts.

---
 rtl/lsu_dmem_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between the core datapath and a word-addressed data memory.
// Turns a RISC-V style load/store into a byte-enabled memory request. Loads are
// extracted and extended from the returned word. The core is stalled until the
// access completes. Misaligned or illegal accesses and memory timeouts are flagged.
module lsu_dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  // core side
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  err_align,
  output logic                  err_bus,
  // memory side
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_t;

  state_t              state;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [CntWidth-1:0] cnt;

  logic                legal;
  logic [3:0]          be_calc;
  logic [31:0]         wdata_calc;
  logic [31:0]         load_data;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;

  // Upper address bits beyond the memory's word range are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^addr_q[31:ADDR_WIDTH+2];

  // Decide whether the incoming request is a legal, naturally aligned access.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~req_addr[0];
      3'b010:  legal = (req_addr[1:0] == 2'b00);
      3'b100:  legal = ~req_we;
      3'b101:  legal = ~req_we & ~req_addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data from the captured request.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr_q[1:0];
        wdata_calc = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << addr_q[1:0];
        wdata_calc = {2{wdata_q[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_q;
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    load_byte = mem_rdata[8*addr_q[1:0] +: 8];
    load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_data = funct3_q[2] ? {24'd0, load_byte}
                                       : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_data = funct3_q[2] ? {16'd0, load_half}
                                       : {{16{load_half[15]}}, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Memory-side outputs are only active while an access is in flight.
  always_comb begin
    mem_req   = (state == StBusy);
    mem_we    = (state == StBusy) & we_q;
    mem_be    = (state == StBusy) ? be_calc : 4'b0000;
    mem_addr  = addr_q[ADDR_WIDTH+1:2];
    mem_wdata = wdata_calc;
  end

  // Core-side handshake: stall from request accept until the response cycle.
  always_comb begin
    stall      = ((state == StIdle) & req_valid) | (state == StBusy);
    resp_valid = (state == StResp);
  end

  // Main control FSM: capture, wait for memory or timeout, one-cycle response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      cnt        <= '0;
      resp_rdata <= 32'd0;
      err_align  <= 1'b0;
      err_bus    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (legal) begin
              state <= StBusy;
            end else begin
              state     <= StResp;
              err_align <= 1'b1;
              if (!req_we) resp_rdata <= 32'd0;
            end
          end
        end
        StBusy: begin
          if (mem_ready) begin
            state <= StResp;
            if (!we_q) resp_rdata <= load_data;
          end else if (cnt == CntLast) begin
            // Memory never answered: give up and report a bus error.
            state   <= StResp;
            err_bus <= 1'b1;
            if (!we_q) resp_rdata <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StResp: begin
          state     <= StIdle;
          cnt       <= '0;
          err_align <= 1'b0;
          err_bus   <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
